// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, frame-shape constants, parity helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam int START_BITS = 1;
    localparam int STOP_BITS  = 1;

    // Total bits on the line for one frame.
    function automatic int frame_bits(input int data_bits, input int parity_bits);
        return START_BITS + data_bits + parity_bits + STOP_BITS;
    endfunction

    // Zero-extended data does not change the XOR, so any width up to 64 fits.
    function automatic logic parity_bit(input logic [63:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular transmit buffer with separate read/write pointers and an occupancy count.
// Latency: write visible on dout one cycle after push (dout is a combinational read of the head).
// Backpressure: push while full is ignored unless pop occurs in the same cycle.
//
// Ports: pclk/preset clock and async active-high reset; push/din enqueue;
//        pop dequeues the head shown on dout; full/empty/count report occupancy.
module uart_tx_fifo #(
    parameter int BITWIDTH   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          pclk,
    input  logic                          preset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [BITWIDTH-1:0]           din,
    output logic [BITWIDTH-1:0]           dout,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [BITWIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wptr;
    logic [AW-1:0]       rptr;
    logic                wr_en;
    logic                rd_en;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    // A pop in the same cycle frees the slot the full write needs.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign dout  = mem[rptr];

    always_ff @(posedge pclk) begin
        if (wr_en) begin
            mem[wptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffers bytes and shifts start, LSB-first data, optional parity, stop on tx.
// Latency: push at edge N with idle FSM and empty buffer drives the start bit after edge N+1.
// Backpressure: tf_TXRDY low when the buffer is full; a push while full without a pop is dropped and flagged on tx_ovf.
//
// Ports: pclk/preset clock and async active-high reset; baud_val bit period minus one;
//        tx_data/tx_wr enqueue; tx serial line; tf_TXRDY not-full; tx_busy activity; tx_ovf drop pulse.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BITWIDTH   = 8,
    parameter int FIFO_DEPTH = 4,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic [BITWIDTH-1:0] baud_val,
    input  logic [BITWIDTH-1:0] tx_data,
    input  logic                tx_wr,
    output logic                tx,
    output logic                tf_TXRDY,
    output logic                tx_busy,
    output logic                tx_ovf
);

    localparam int IW = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t           state_q, state_d;
    logic [BITWIDTH-1:0] cnt_q, cnt_d;
    logic [BITWIDTH-1:0] baud_q, baud_d;
    logic [BITWIDTH-1:0] shreg_q, shreg_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                par_q, par_d;
    logic                tx_q, tx_d;
    logic                ovf_q;
    logic                bit_end;
    logic                start_frame;

    logic                fifo_pop;
    logic [BITWIDTH-1:0] fifo_dout;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;

    uart_tx_fifo #(
        .BITWIDTH   (BITWIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .pclk   (pclk),
        .preset (preset),
        .push   (tx_wr),
        .pop    (fifo_pop),
        .din    (tx_data),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign bit_end  = (cnt_q == '0);
    assign tx       = tx_q;
    assign tf_TXRDY = !fifo_full;
    assign tx_busy  = (state_q != ST_IDLE) || (fifo_count != '0);
    assign tx_ovf   = ovf_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q - 1'b1;
        baud_d      = baud_q;
        shreg_d     = shreg_q;
        idx_d       = idx_q;
        par_d       = par_q;
        tx_d        = tx_q;
        start_frame = 1'b0;
        fifo_pop    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d       = cnt_q;
                tx_d        = 1'b1;
                start_frame = !fifo_empty;
            end
            ST_START: begin
                if (bit_end) begin
                    tx_d    = shreg_q[0];
                    idx_d   = '0;
                    cnt_d   = baud_q;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d = baud_q;
                    if (idx_q == IW'(BITWIDTH - 1)) begin
                        if (PARITY_EN) begin
                            tx_d    = par_q;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        // shreg[0] is the bit on the line; the next one sits at [1].
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    cnt_d   = baud_q;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    // Chain straight into the next frame when data is waiting.
                    start_frame = !fifo_empty;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        // The divisor is captured here so a mid-frame change waits for the next frame.
        if (start_frame) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_dout;
            par_d    = parity_bit(64'(fifo_dout), PARITY_ODD);
            baud_d   = baud_val;
            cnt_d    = baud_val;
            tx_d     = 1'b0;
            state_d  = ST_START;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            baud_q  <= '0;
            shreg_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            baud_q  <= baud_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ovf_q   <= tx_wr && fifo_full && !fifo_pop;
        end
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmit stage of the UART, directly downstream of the APB register slave. Takes the transmit byte and baud divisor published by the slave, buffers bytes in a small FIFO, and shifts each one out on the `tx` line as an asynchronous frame: start bit, data LSB-first, optional parity, one stop bit. It returns `tf_TXRDY` to the slave as its transmit-ready status.

## Interface

Parameters:
- `BITWIDTH`, default 8: data width and baud divisor width.
- `FIFO_DEPTH`, default 4: number of transmit buffer entries; must be a power of two.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 1 selects odd parity, 0 selects even parity. Ignored when `PARITY_EN`=0.

Ports:
- `pclk`  in  1  system clock; all logic runs on the rising edge.
- `preset`  in  1  reset, asynchronous, active-high.
- `baud_val`  in  BITWIDTH  bit period minus one, in `pclk` cycles.
- `tx_data`  in  BITWIDTH  byte to enqueue.
- `tx_wr`  in  1  one-cycle push strobe for `tx_data`.
- `tx`  out  1  serial line; idles high.
- `tf_TXRDY`  out  1  FIFO not full.
- `tx_busy`  out  1  a frame is in progress, or the FIFO is non-empty.
- `tx_ovf`  out  1  one-cycle pulse when a push is dropped.

## Operation

Reset values:
- `tx`=1, `tf_TXRDY`=1, `tx_busy`=0, `tx_ovf`=0.
- FIFO empty, pointers 0, FSM in IDLE.
- Asserting `preset` mid-frame aborts the frame immediately: `tx` goes to 1 and FIFO contents are discarded.

FIFO:
- Circular buffer with separate read and write pointers plus a count of width clog2(FIFO_DEPTH)+1.
- Pointers wrap modulo FIFO_DEPTH.
- `tx_wr` while not full: write `tx_data` and increment the count.
- `tx_wr` while full with no pop in the same cycle: the data is dropped and `tx_ovf` pulses high for one cycle.
- `tx_wr` while full with a pop in the same cycle: the write is accepted and the count is unchanged.
- `tx_wr` while empty is never bypassed; the byte always passes through the FIFO.

Baud counter:
- Down-counter loaded with `baud_val` at every bit boundary.
- A bit ends when the counter reads 0, so each bit lasts `baud_val`+1 cycles.
- `baud_val` is latched at frame start. A change mid-frame takes effect on the next frame.
- `baud_val`=0 gives a 1-cycle bit.

FSM (states live in the shared package):
- **IDLE:** `tx`=1. If the FIFO is non-empty: pop into the shift register, compute parity, load the counter, drive `tx`=0, go to START.
- **START:** at bit end, drive bit 0 and go to DATA with bit index 0.
- **DATA:** at bit end, if index = BITWIDTH-1 go to PARITY (when `PARITY_EN`) or STOP; otherwise shift and increment the index.
- **PARITY:** `tx` = XOR of data, inverted when `PARITY_ODD`. At bit end go to STOP.
- **STOP:** `tx`=1. At bit end, if the FIFO is non-empty, pop and go straight to START with no idle gap; otherwise go to IDLE.

Frame length is (BITWIDTH+2+PARITY_EN)×(`baud_val`+1) cycles.

## Timing

- `tx` is driven directly from a register, with no combinational path from inputs.
- The slave updates `tx_data` on the falling edge. This block samples it on the following rising edge, so the data is stable half a cycle before the sample.
- Latency: `tx_wr` sampled at edge N with the FSM in IDLE and the FIFO empty gives `tx` falling after edge N+1.
- `tf_TXRDY` reflects the count after edge N; it deasserts in the cycle after the FIFO_DEPTH-th accepted write.
- `tx_busy` rises with the first accepted write and falls in the cycle after STOP ends with the FIFO empty.

## Structure

Shared package `uart_pkg`:
- FSM state enum: IDLE, START, DATA, PARITY, STOP.
- Frame-length localparams.
- Parity helper function.

Sub-module `uart_tx_fifo`:
- Parameterised by BITWIDTH and FIFO_DEPTH.
- Ports: push, pop, din, dout, full, empty, count.
- The FSM, baud counter and shift register remain in `uart_tx`.

## Test plan

- **Single byte:** reset, `baud_val`=3, push 0xA5 → `tx` low after 1 cycle. The line then carries 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each bit 4 cycles wide, for 40 cycles total. `tx_busy` then falls.
- **Back-to-back:** push 0x00 and 0xFF in consecutive cycles → two frames with no idle cycle between the stop bit and the second start bit.
- **Overflow:** `baud_val`=15, push 6 bytes in consecutive cycles, FIFO_DEPTH=4.
  - The first byte is popped into the shift register, so one slot is freed.
  - `tf_TXRDY` drops after the 5th push.
  - The 6th push pulses `tx_ovf`.
  - Exactly 5 frames are transmitted, in order.
- **Parity:** `PARITY_EN`=1, `PARITY_ODD`=0, push 0x07 → parity bit 1. With `PARITY_ODD`=1 → parity bit 0. The frame is 11 bits.
- **Reset mid-frame:** assert `preset` during DATA bit 3 with 2 bytes queued → `tx`=1 immediately and `tf_TXRDY`=1. After release, no frame is sent.
- **Baud change:** change `baud_val` from 1 to 5 mid-frame → the current frame keeps 2-cycle bits and the next frame uses 6-cycle bits.
